// File: rtl/uart_pkg.sv
// Shared UART types and helpers: receiver state encoding, data width and the
// baud divisor calculation used when sizing CLOCKS_PER_BAUD.
package uart_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_rx_state_t;

  localparam int UART_DATA_BITS = 8;

  // Rounded clk cycles per bit for a given clock and baud rate.
  function automatic int baud_div(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-stage flop synchronizer for a single asynchronous input bit.
// Reset value is configurable so idle-high lines come out of reset inactive.
module sync_ff #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] stage_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_reg <= {SYNC_STAGES{RESET_VAL}};
    end else begin
      stage_reg <= {stage_reg[SYNC_STAGES-2:0], d};
    end
  end

  assign q = stage_reg[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: synchronizes rx, re-aligns on each start edge and emits
// one-cycle valid/framing-error strobes. Define UART_RX_MAJORITY_EN for 2-of-3 voting.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int CLOCKS_PER_BAUD = baud_div(100_000_000, 115_200),
  parameter int SYNC_STAGES     = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      rx,
  output logic [UART_DATA_BITS-1:0] data_o,
  output logic                      valid_o,
  output logic                      frame_err_o,
  output logic                      busy_o
);

  localparam int CW  = $clog2(CLOCKS_PER_BAUD);
  localparam int BW  = $clog2(UART_DATA_BITS);
  localparam int MID = CLOCKS_PER_BAUD / 2;
`ifdef UART_RX_MAJORITY_EN
  localparam int START_PT = MID + 1;
`else
  localparam int START_PT = MID - 1;
`endif
  localparam logic [CW-1:0] START_PT_C = CW'(START_PT);
  localparam logic [CW-1:0] LAST_C     = CW'(CLOCKS_PER_BAUD - 1);
  localparam logic [BW-1:0] LAST_BIT_C = BW'(UART_DATA_BITS - 1);

  logic                      rx_s;
  uart_rx_state_t            state_reg, state_next;
  logic [CW-1:0]             cnt_reg, cnt_next;
  logic [BW-1:0]             bit_idx_reg, bit_idx_next;
  logic [UART_DATA_BITS-1:0] shift_reg, shift_next;
  logic [UART_DATA_BITS-1:0] data_reg, data_next;
  logic                      valid_reg, valid_next;
  logic                      ferr_reg, ferr_next;
  logic                      armed_reg, armed_next;
  logic [CW-1:0]             sample_pt;
  logic                      at_sample;
  logic                      bit_s;

  sync_ff #(
    .SYNC_STAGES (SYNC_STAGES),
    .RESET_VAL   (1'b1)
  ) u_rx_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx),
    .q     (rx_s)
  );

  assign sample_pt = (state_reg == START) ? START_PT_C : LAST_C;
  assign at_sample = (cnt_reg == sample_pt);

`ifdef UART_RX_MAJORITY_EN
  // Two earlier samples are banked; the third is rx_s at the decision cycle.
  logic [1:0] vote_reg;
  logic       vote_en;

  assign vote_en = (state_reg != IDLE) &&
                   ((cnt_reg == sample_pt - CW'(1)) || (cnt_reg == sample_pt - CW'(2)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vote_reg <= 2'b11;
    end else if (vote_en) begin
      vote_reg <= {vote_reg[0], rx_s};
    end
  end

  assign bit_s = (vote_reg[1] & vote_reg[0]) | (vote_reg[1] & rx_s) | (vote_reg[0] & rx_s);
`else
  assign bit_s = rx_s;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      bit_idx_reg <= '0;
      shift_reg   <= '0;
      data_reg    <= '0;
      valid_reg   <= 1'b0;
      ferr_reg    <= 1'b0;
      armed_reg   <= 1'b1;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      bit_idx_reg <= bit_idx_next;
      shift_reg   <= shift_next;
      data_reg    <= data_next;
      valid_reg   <= valid_next;
      ferr_reg    <= ferr_next;
      armed_reg   <= armed_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg + CW'(1);
    bit_idx_next = bit_idx_reg;
    shift_next   = shift_reg;
    data_next    = data_reg;
    valid_next   = 1'b0;
    ferr_next    = 1'b0;
    armed_next   = armed_reg;

    unique case (state_reg)
      IDLE: begin
        cnt_next = '0;
        // After a framing error the line must go high before a new start counts.
        if (rx_s) begin
          armed_next = 1'b1;
        end
        if (armed_reg && !rx_s) begin
          state_next = START;
        end
      end
      START: begin
        if (at_sample) begin
          cnt_next     = '0;
          bit_idx_next = '0;
          state_next   = bit_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (at_sample) begin
          cnt_next     = '0;
          shift_next   = {bit_s, shift_reg[UART_DATA_BITS-1:1]};
          bit_idx_next = bit_idx_reg + BW'(1);
          if (bit_idx_reg == LAST_BIT_C) begin
            state_next = STOP;
          end
        end
      end
      STOP: begin
        if (at_sample) begin
          cnt_next   = '0;
          state_next = IDLE;
          if (bit_s) begin
            valid_next = 1'b1;
            data_next  = shift_reg;
          end else begin
            ferr_next  = 1'b1;
            armed_next = 1'b0;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign data_o      = data_reg;
  assign valid_o     = valid_reg;
  assign frame_err_o = ferr_reg;
  assign busy_o      = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_rx_core.sv
// Scoreboard bench for uart_rx_core at CLOCKS_PER_BAUD=8: frames are queued as
// they are driven and matched against valid/frame-error strobes by a monitor.
module tb_uart_rx_core;

  localparam int CPB  = 8;
  localparam int SYNC = 2;
  localparam int MID  = CPB / 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] data_o;
  logic       valid_o;
  logic       frame_err_o;
  logic       busy_o;

  always #5 clk = ~clk;

  uart_rx_core #(
    .CLOCKS_PER_BAUD (CPB),
    .SYNC_STAGES     (SYNC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx          (rx),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .frame_err_o (frame_err_o),
    .busy_o      (busy_o)
  );

  typedef struct packed {
    logic       is_err;
    logic [7:0] data;
  } exp_t;

  exp_t       sb_q[$];
  exp_t       mon_exp;
  int         n_checks = 0;
  int         n_fail = 0;
  int         n_valid = 0;
  int         n_err = 0;
  int         n_valid_exp = 0;
  int         n_err_exp = 0;
  logic [7:0] last_good = 8'h00;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_ok(input logic [7:0] d);
    sb_q.push_back('{is_err: 1'b0, data: d});
    last_good = d;
    n_valid_exp++;
  endtask

  task automatic expect_err();
    sb_q.push_back('{is_err: 1'b1, data: last_good});
    n_err_exp++;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives the first nbits of {stop, data, start}; glitch inverts one cycle just after mid-bit.
  task automatic send_frame(input logic [7:0] d, input logic stop, input bit glitch, input int nbits);
    logic [9:0] fr;
    fr = {stop, d, 1'b0};
    for (int b = 0; b < nbits; b++) begin
      for (int c = 0; c < CPB; c++) begin
        rx = fr[b] ^ (glitch && (c == MID + 1));
        tick(1);
      end
    end
    rx = 1'b1;
  endtask

  always @(negedge clk) begin
    if (rst_n && (valid_o || frame_err_o)) begin
      if (valid_o) n_valid++;
      if (frame_err_o) n_err++;
      check_eq("strobe_exclusive", {31'd0, valid_o & frame_err_o}, 32'd0);
      check_eq("sb_nonempty", {31'd0, sb_q.size() != 0}, 32'd1);
      if (sb_q.size() != 0) begin
        mon_exp = sb_q.pop_front();
        $display("strobe valid=%0b err=%0b data=0x%02h | expected err=%0b data=0x%02h",
                 valid_o, frame_err_o, data_o, mon_exp.is_err, mon_exp.data);
        check_eq("strobe_kind", {30'd0, valid_o, frame_err_o},
                 mon_exp.is_err ? 32'd1 : 32'd2);
        check_eq("strobe_data", {24'd0, data_o}, {24'd0, mon_exp.data});
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit busy_seen;
    int v0, e0;

    tick(3);
    check_eq("rst_data", {24'd0, data_o}, 32'd0);
    check_eq("rst_valid", {31'd0, valid_o}, 32'd0);
    check_eq("rst_ferr", {31'd0, frame_err_o}, 32'd0);
    check_eq("rst_busy", {31'd0, busy_o}, 32'd0);
    rst_n = 1'b1;
    tick(2 * CPB);

    // Single good frame.
    expect_ok(8'hA5);
    send_frame(8'hA5, 1'b1, 1'b0, 10);
    tick(CPB);
    check_eq("a5_busy_after", {31'd0, busy_o}, 32'd0);
    check_eq("a5_valid_cnt", n_valid, n_valid_exp);
    $display("frame 0xA5 done, data_o=0x%02h", data_o);

    // Back-to-back frames with no idle gap.
    expect_ok(8'h00);
    expect_ok(8'hFF);
    expect_ok(8'h3C);
    send_frame(8'h00, 1'b1, 1'b0, 10);
    send_frame(8'hFF, 1'b1, 1'b0, 10);
    send_frame(8'h3C, 1'b1, 1'b0, 10);
    tick(2 * CPB);
    check_eq("b2b_valid_cnt", n_valid, n_valid_exp);
    $display("back-to-back frames done, data_o=0x%02h", data_o);

    // Stop bit low: framing error, data held.
    expect_err();
    send_frame(8'h55, 1'b0, 1'b0, 10);
    tick(2 * CPB);
    check_eq("ferr_data_hold", {24'd0, data_o}, 32'h3C);
    check_eq("ferr_err_cnt", n_err, n_err_exp);
    $display("framing-error frame done, data_o=0x%02h", data_o);

    // Break condition: one error only, then normal reception resumes.
    expect_err();
    rx = 1'b0;
    tick(40 * CPB);
    rx = 1'b1;
    tick(2 * CPB);
    check_eq("break_err_cnt", n_err, n_err_exp);
    expect_ok(8'h81);
    send_frame(8'h81, 1'b1, 1'b0, 10);
    tick(2 * CPB);
    check_eq("after_break_data", {24'd0, data_o}, 32'h81);
    $display("break + frame 0x81 done, data_o=0x%02h", data_o);

    // Short low glitch in idle.
    v0 = n_valid;
    e0 = n_err;
    busy_seen = 1'b0;
    rx = 1'b0;
    tick(2);
    rx = 1'b1;
    for (int i = 0; i < MID + SYNC + 2; i++) begin
      busy_seen |= busy_o;
      tick(1);
    end
    check_eq("glitch_busy_seen", {31'd0, busy_seen}, 32'd1);
    check_eq("glitch_busy_low", {31'd0, busy_o}, 32'd0);
    tick(2 * CPB);
    check_eq("glitch_no_valid", n_valid, v0);
    check_eq("glitch_no_err", n_err, e0);
    $display("idle glitch done, busy_seen=%0b", busy_seen);

    // Reset in the middle of the data bits.
    send_frame(8'hC3, 1'b1, 1'b0, 5);
    rx = 1'b0;
    rst_n = 1'b0;
    #1;
    check_eq("midrst_data", {24'd0, data_o}, 32'd0);
    check_eq("midrst_busy", {31'd0, busy_o}, 32'd0);
    last_good = 8'h00;
    tick(2);
    rx = 1'b1;
    tick(1);
    rst_n = 1'b1;
    tick(2 * CPB);
    expect_ok(8'h7E);
    send_frame(8'h7E, 1'b1, 1'b0, 10);
    tick(2 * CPB);
    check_eq("after_rst_data", {24'd0, data_o}, 32'h7E);
    $display("mid-frame reset + frame 0x7E done, data_o=0x%02h", data_o);

`ifdef UART_RX_MAJORITY_EN
    // One-cycle inverted pulse inside every bit must be voted out.
    expect_ok(8'h96);
    send_frame(8'h96, 1'b1, 1'b1, 10);
    tick(2 * CPB);
    check_eq("majority_data", {24'd0, data_o}, 32'h96);
    $display("glitched frame 0x96 done, data_o=0x%02h", data_o);
`endif

    check_eq("sb_drained", sb_q.size(), 32'd0);
    check_eq("total_valid", n_valid, n_valid_exp);
    check_eq("total_err", n_err, n_err_exp);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_core.md
Name: uart_rx_core

Overview:
- Serial receive front end feeding the debug core's bridge. Takes the raw FPGA pin `rx` (USB-UART on Nexys A7) and emits one byte per valid 8N1 frame as a single-cycle strobe.
- Sits between the board pin and the core's message decoder, which consumes `data_o`/`valid_o`.
- Oversamples with a baud counter and re-aligns on every start edge.
- Reports framing errors; never back-pressures, because UART cannot be stalled.

Parameters:
- CLOCKS_PER_BAUD, 868: clk cycles per bit (100 MHz / 115200); must be >= 4.
- SYNC_STAGES, 2: flip-flop stages in the rx metastability synchronizer; must be >= 2.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- rx  in  1  raw asynchronous serial line; idle high.
- data_o  out  8  received byte, LSB-first assembled; held until next valid_o.
- valid_o  out  1  one-cycle strobe: data_o holds a good frame.
- frame_err_o  out  1  one-cycle strobe: stop bit sampled low.
- busy_o  out  1  high from start-edge detection until frame end.

Behaviour:
- Reset (async assert, sync release): data_o=0, valid_o=0, frame_err_o=0, busy_o=0, state=IDLE, synchronizer flops=1 (line idle), baud counter=0, bit index=0.
- rx passes through SYNC_STAGES flops; all logic uses the synchronized value rx_s. There is an SYNC_STAGES-cycle input latency.
- Counter width is $clog2(CLOCKS_PER_BAUD). MID = CLOCKS_PER_BAUD/2 (integer division).
- State IDLE:
  - When rx_s==0, go to START, clear the counter, assert busy_o.
- State START:
  - Count to MID-1, then sample rx_s.
  - If 0, go to DATA with bit index 0 and the counter cleared.
  - If 1 (glitch), return to IDLE with no strobe and busy_o low.
- State DATA:
  - Sample at counter==CLOCKS_PER_BAUD-1, which is one full bit from the previous sample point (mid-bit).
  - Shift right into a shift register: new bit enters bit 7.
  - After bit index 7, go to STOP.
- State STOP:
  - Sample at counter==CLOCKS_PER_BAUD-1.
  - If 1: data_o <= shift register and valid_o=1 for exactly one cycle.
  - If 0: frame_err_o=1 for one cycle and data_o is unchanged.
  - Either way, go to IDLE and drop busy_o on the same cycle.
- After a stop-bit error, IDLE re-arms only once rx_s has been seen high for at least one cycle. This prevents a break condition (line held low) from generating back-to-back frames. A break yields exactly one frame_err_o.
- Back-to-back frames: a start edge in the first cycle after STOP is accepted. There are no dead cycles beyond the half-bit of the stop sampled.
- valid_o and frame_err_o are never high in the same cycle.
- Reset mid-frame aborts the frame: no strobe, and outputs return to reset values.
- Frame latency: valid_o rises SYNC_STAGES + 9.5×CLOCKS_PER_BAUD (±1) cycles after the rx start edge.

Optional Feature:
- Macro: UART_RX_MAJORITY_EN.
- Defined:
  - Each sample (start, data, stop) is the 2-of-3 majority of rx_s at counter values MID-1, MID and MID+1 relative to bit centre.
  - The decision is taken at MID+1 in START; sample timing in DATA/STOP shifts accordingly but the bit period is unchanged.
  - Requires CLOCKS_PER_BAUD >= 6.
  - Single-cycle glitches inside a bit are rejected.
- Undefined: single sample at the centre point; no vote registers are synthesized.

Decomposition:
- Package uart_pkg:
  - typedef enum logic [1:0] uart_rx_state_t {IDLE, START, DATA, STOP}.
  - localparam UART_DATA_BITS=8.
  - Function baud_div(clk_hz, baud) used by top-level instantiation.
- One natural sub-module: sync_ff (parameterized SYNC_STAGES, reset value 1).
  - Reused later for the uart_tx enable and button inputs.

Test Plan:
- CLOCKS_PER_BAUD=8; send 0xA5 8N1 -> exactly one valid_o pulse, data_o=0xA5, frame_err_o never high, busy_o low after strobe.
- Send 0x00, 0xFF, 0x3C back-to-back with zero idle between stop and next start -> three valid_o pulses with data 0x00, 0xFF, 0x3C in order.
- Frame 0x55 with stop bit forced 0 -> frame_err_o one pulse, no valid_o, data_o keeps previous 0x3C.
- Hold rx low for 40 bit times, then release -> exactly one frame_err_o. Next frame 0x81 is received correctly.
- Glitch: rx low for 2 cycles (< MID) during IDLE -> returns to IDLE, no strobes, busy_o pulses then drops by cycle MID+SYNC_STAGES.
- Assert rst_n low mid-DATA of 0xC3, release, send 0x7E -> no strobe for the aborted frame, then data_o=0x7E valid.
- With UART_RX_MAJORITY_EN, a 1-cycle inverted pulse at the centre of every bit of 0x96 -> data_o=0x96.
